mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb.sv | 139 +++++++++++++
 tb/tb_mux_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
// mux_arb: two-source burst-locking arbiter in front of a 2:1 mux with a
// single-entry registered output stage.
// Optional build macro MUX_ARB_ASSERT_EN compiles in a behaviour-check block
// of immediate assertions. It does not change the RTL behaviour.
module mux_arb #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y,
  output logic              y_src,
  input  logic              y_ready
);

  // Lock state: a burst that started with a non-last beat keeps its owner.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED_A = 2'd1,
    ST_LOCKED_B = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_gnt;  // 1 = A granted most recently, 0 = B
  logic              r_y_valid;
  logic [DATA_W-1:0] r_y;
  logic              r_y_src;

  logic              w_space;
  logic              w_pick_a;
  logic              w_pick_b;
  logic              w_sel;
  logic [DATA_W-1:0] w_mux;
  logic              w_accept;
  logic              w_acc_last;

  // The output register can take a beat if it is empty or being drained now.
  assign w_space = !r_y_valid || y_ready;

  // Arbitration. Picks are qualified by valid, so a pick is an accept.
  // Data and last never enter this decision.
  always_comb begin
    w_pick_a = 1'b0;
    w_pick_b = 1'b0;
    if (w_space) begin
      case (r_state)
        ST_LOCKED_A: w_pick_a = a_valid;
        ST_LOCKED_B: w_pick_b = b_valid;
        default: begin
          if (a_valid && b_valid) begin
            // Tie: the source that was not granted last time wins.
            w_pick_a = !r_last_gnt;
            w_pick_b = r_last_gnt;
          end else begin
            w_pick_a = a_valid;
            w_pick_b = b_valid;
          end
        end
      endcase
    end
  end

  // Readies are forced low while reset is held; flops see the ungated picks.
  assign a_ready = rst_n && w_pick_a;
  assign b_ready = rst_n && w_pick_b;

  // Mux select follows the A grant; when nobody is granted it idles on B.
  assign w_sel      = w_pick_a;
  assign w_mux      = w_sel ? a_data : b_data;
  assign w_accept   = w_pick_a || w_pick_b;
  assign w_acc_last = w_sel ? a_last : b_last;

  // Lock FSM, last-grant memory and output stage, all updated on accept/drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCKED;
      r_last_gnt <= 1'b0;
      r_y_valid  <= 1'b0;
      r_y        <= '0;
      r_y_src    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_y        <= w_mux;
        r_y_src    <= w_sel;
        r_y_valid  <= 1'b1;
        r_last_gnt <= w_sel;
        if (w_acc_last) begin
          r_state <= ST_UNLOCKED;
        end else begin
          r_state <= w_sel ? ST_LOCKED_A : ST_LOCKED_B;
        end
      end else if (y_ready) begin
        // Drain with nothing new: y and y_src keep their last value.
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_valid = r_y_valid;
  assign y       = r_y;
  assign y_src   = r_y_src;

`ifdef MUX_ARB_ASSERT_EN
  // Behaviour checks on the live grant and mux signals.
  always_comb begin
    assert (!(a_ready && b_ready))
      else $error("mux_arb: a_ready and b_ready both high");
    if (!w_space) begin
      assert (!a_ready && !b_ready)
        else $error("mux_arb: ready asserted with no output space");
    end
    if (r_state == ST_LOCKED_A) begin
      assert (!b_ready)
        else $error("mux_arb: b_ready high while locked to A");
    end
    if (r_state == ST_LOCKED_B) begin
      assert (!a_ready)
        else $error("mux_arb: a_ready high while locked to B");
    end
    if (w_sel && a_ready && a_valid) begin
      assert (w_mux == a_data)
        else $error("mux_arb: mux output differs from a_data on A accept");
    end
    if (!w_sel && b_ready && b_valid) begin
      assert (w_mux == b_data)
        else $error("mux_arb: mux output differs from b_data on B accept");
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: scoreboard bench for mux_arb. A small reference model predicts
// grants. Accepted beats are queued and compared when they appear on y.
module tb_mux_arb;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       y_valid, y_src, y_ready;
  logic [7:0] y;

  int n_vec;
  int n_err;

  // Reference model state
  logic       m_locked;
  logic       m_owner;     // 1 = A
  logic       m_last_gnt;  // 1 = A
  logic       m_yv;
  logic [8:0] sb_q[$];     // {src, data}

  mux_arb #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y       (y),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_owner    = 1'b0;
    m_last_gnt = 1'b0;
    m_yv       = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks, advances.
  task automatic cycle(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl,
                       input logic yr);
    logic sp, ga, gb;
    logic [8:0] head;
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    y_ready = yr;
    #2;
    sp = !m_yv || yr;
    ga = 1'b0;
    gb = 1'b0;
    if (sp) begin
      if (m_locked) begin
        ga = m_owner && av;
        gb = !m_owner && bv;
      end else if (av && bv) begin
        ga = !m_last_gnt;
        gb = m_last_gnt;
      end else begin
        ga = av;
        gb = bv;
      end
    end
    check("a_ready", {31'd0, a_ready}, {31'd0, ga});
    check("b_ready", {31'd0, b_ready}, {31'd0, gb});
    check("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
    if (m_yv && sb_q.size() > 0) begin
      head = sb_q[0];
      check("y_beat", {23'd0, y_src, y}, {23'd0, head});
    end
    if (m_yv && yr) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      m_yv = 1'b0;
    end
    if (ga || gb) begin
      sb_q.push_back(ga ? {1'b1, ad} : {1'b0, bd});
      m_yv       = 1'b1;
      m_last_gnt = ga;
      m_owner    = ga;
      m_locked   = ga ? !al : !bl;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; called at a negedge.
  task automatic reset_pulse();
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_y_src", {31'd0, y_src}, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    y_ready = 1'b0;
    #3;
    check("init_y_valid", {31'd0, y_valid}, 32'd0);
    check("init_y", {24'd0, y}, 32'd0);
    @(negedge clk);
    // Readies must stay low while reset is held even with sources valid.
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("init_a_ready", {31'd0, a_ready}, 32'd0);
    check("init_b_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating ties of single-beat bursts: A, B, A.
    for (int i = 0; i < 3; i++) cycle(1, 8'h11, 1, 1, 8'h22, 1, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    check("tie_last_src", {31'd0, y_src}, 32'd1);

    // B once so A wins the next tie, then a 3-beat A burst against a busy B.
    cycle(0, 8'h00, 0, 1, 8'hB0, 1, 1);
    cycle(1, 8'hA0, 0, 1, 8'hB1, 1, 1);
    cycle(1, 8'hA1, 0, 1, 8'hB1, 1, 1);
    cycle(1, 8'hA2, 1, 1, 8'hB1, 1, 1);
    cycle(1, 8'hA3, 1, 1, 8'hB1, 1, 1);
    check("burst_then_b", {23'd0, y_src, y}, {23'd0, 1'b0, 8'hB1});
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Hold: 0x33 stays on y for 4 stalled cycles with both sources valid.
    cycle(1, 8'h33, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'h44, 1, 1, 8'h55, 1, 0);
    check("hold_y", {24'd0, y}, 32'h33);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Reset in the middle of a locked A burst discards lock and held beat.
    cycle(0, 8'h00, 0, 1, 8'h01, 1, 1);
    cycle(1, 8'hC0, 0, 1, 8'hD0, 1, 1);
    cycle(1, 8'hC1, 0, 1, 8'hD0, 1, 0);
    reset_pulse();
    cycle(1, 8'hE0, 1, 1, 8'hF0, 1, 1);
    cycle(1, 8'hE1, 1, 1, 8'hF1, 1, 1);
    check("post_rst_b", {23'd0, y_src, y}, {23'd0, 1'b0, 8'hF1});
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // B only with y_ready toggling 1,0,1.
    cycle(0, 8'h00, 0, 1, 8'h61, 1, 1);
    cycle(0, 8'h00, 0, 1, 8'h62, 1, 0);
    cycle(0, 8'h00, 0, 1, 8'h62, 1, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    check("toggle_last", {24'd0, y}, 32'h62);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
